// File: rtl/div_share_sched_pkg.sv
// div_share_sched_pkg: shared FSM encoding and divide-by-zero quotient for div_share_sched
package div_share_sched_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
    // Sliced down to the datapath width at the point of use.
    localparam int DZ_MAX_W = 64;
    localparam logic [DZ_MAX_W-1:0] DZ_QUOT = '1;
endpackage

// File: rtl/div.sv
// DIV: shared combinational unsigned divider (quotient truncated toward zero)
// Ports: A dividend, B divisor, Q quotient (undefined when B is zero)
module DIV #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q
);
    assign Q = A / B;
endmodule

// File: rtl/div_share_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker starting the search at i_ptr
// Ports: i_req request vector, i_ptr search start, o_gnt one-hot grant, o_id encoded grant, o_any some request present
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_id,
    output logic               o_any
);
    int idx;
    always_comb begin
        o_gnt = '0;
        o_id  = '0;
        o_any = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(i_ptr) + k) % NUM_REQ;
            if (!o_any && i_req[idx]) begin
                o_any      = 1'b1;
                o_gnt[idx] = 1'b1;
                o_id       = ID_W'(idx);
            end
        end
    end
endmodule

// File: rtl/div_share_sched.sv
// div_share_sched: round-robin scheduler sharing one DIV among NUM_REQ requesters
// Ports: Clk/Rst (sync, active-high); req_valid/req_A/req_B/req_ready accept handshake;
//        resp_valid/resp_ready/resp_Q/resp_dz held response to the granted requester; busy when not IDLE
module div_share_sched
    import div_share_sched_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_A,
    input  logic [NUM_REQ*WIDTH-1:0] req_B,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]         resp_Q,
    output logic                     resp_dz,
    output logic                     busy
);
    state_t             r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_gnt_id;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_q;
    logic               r_dz;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_id;
    logic               w_any;
    logic [WIDTH-1:0]   w_q;
    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .i_req (req_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_id  (w_id),
        .o_any (w_any)
    );
    // Divider sees only the operand registers so its inputs hold for the whole EXEC cycle.
    DIV #(.WIDTH(WIDTH)) u_div (
        .A (r_a),
        .B (r_b),
        .Q (w_q)
    );
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_gnt_id <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_q      <= '0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_a      <= req_A[w_id*WIDTH +: WIDTH];
                    r_b      <= req_B[w_id*WIDTH +: WIDTH];
                    r_gnt_id <= w_id;
                    r_state  <= EXEC;
                end
                EXEC: begin
                    // Zero divisor bypasses the undefined DIV output with a fixed all-ones quotient.
                    r_q     <= (r_b == '0) ? DZ_QUOT[WIDTH-1:0] : w_q;
                    r_dz    <= (r_b == '0);
                    r_state <= RESP;
                end
                RESP: if (resp_ready[r_gnt_id]) begin
                    r_rr_ptr <= (r_gnt_id == ID_W'(NUM_REQ-1)) ? '0 : r_gnt_id + 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign req_ready  = (r_state == IDLE) ? w_gnt : '0;
    assign resp_valid = (r_state == RESP) ? (NUM_REQ'(1) << r_gnt_id) : '0;
    assign resp_Q     = (r_state == RESP) ? r_q : '0;
    assign resp_dz    = (r_state == RESP) && r_dz;
    assign busy       = (r_state != IDLE);
endmodule
